lcd_rom_window_ctrl: RTL and testbench
======================================

Name: lcd_rom_window_ctrl

Overview:
Sequences a 1-bit-per-pixel image ROM (registered read, 1-cycle latency, 17-bit address) for the LCD pixel pipeline. Places a fixed-size IMG_W x IMG_H bitmap window at a run-time position on the H_DISP x V_DISP panel. Walks the ROM address linearly as the LCD driver requests pixels inside the window. Maps each bit to foreground/background colour with fixed 2-cycle latency.

Parameters:
H_DISP, 480, active pixels per line
V_DISP, 272, active lines per frame
IMG_W, 256, image width in pixels
IMG_H, 128, image height in lines (IMG_W*IMG_H <= 2**ADDR_WIDTH)
ADDR_WIDTH, 17, ROM address width
COLOR_W, 16, pixel colour width (RGB565)
BLINK_PERIOD, 32, frames per blink cycle (BLINK_EN only, even, >=2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
frame_start  in  1  one-cycle pulse before first pixel of each frame
pix_req  in  1  LCD driver requests pixel at pix_x/pix_y this cycle
pix_x  in  11  requested column, 0..H_DISP-1
pix_y  in  11  requested line, 0..V_DISP-1
win_x0  in  11  window left column, sampled on frame_start
win_y0  in  11  window top line, sampled on frame_start
fg_color  in  COLOR_W  colour for ROM bit 1
bg_color  in  COLOR_W  colour for ROM bit 0 and outside window
rom_addr  out  ADDR_WIDTH  ROM address, driven directly from address counter
rom_data  in  1  ROM output, valid one cycle after rom_addr
pix_data  out  COLOR_W  pixel colour
pix_valid  out  1  pix_data valid, 2 cycles after pix_req
frame_done  out  1  one-cycle pulse when last image pixel address issued
active  out  1  high in state ACTIVE

Behaviour:
- Clock is clk; reset is synchronous and active-high on rst.
- Reset: rom_addr=0, pix_data=0, pix_valid=0, frame_done=0, active=0, state=IDLE, latched window=(0,0), pipeline flags cleared.
- States:
  - IDLE: no frame seen yet.
  - ACTIVE: image fetch in progress.
  - DONE: all IMG_W*IMG_H addresses issued.
- Transitions: frame_start in any state -> ACTIVE; ACTIVE -> DONE on issue of address IMG_W*IMG_H-1.
- On frame_start: addr counter <= 0. Latch wx = min(win_x0, H_DISP-IMG_W) and wy = min(win_y0, V_DISP-IMG_H). Clamping guarantees every window pixel is requested, so the linear counter stays aligned.
- in_win = pix_req & state==ACTIVE & wx<=pix_x<wx+IMG_W & wy<=pix_y<wy+IMG_H. Uses latched window.
- Cycle N (pix_req=1), at end of N:
  - ROM samples rom_addr.
  - If in_win, counter increments.
  - At address IMG_W*IMG_H-1, counter holds, frame_done pulses, state -> DONE.
  - in_win_d1 <= in_win; req_d1 <= pix_req.
- At end of N+1: pix_valid <= req_d1; pix_data <= in_win_d1 ? (rom_data ? fg_color : bg_color) : bg_color. Result is visible in cycle N+2.
- pix_req with no frame_start, or outside window: pix_valid still follows at N+2 with bg_color; counter unchanged.
- pix_req low: pix_valid=0 at N+2; pix_data holds last value.
- frame_start coincident with pix_req: frame_start wins. Counter reset and window relatched first; that request evaluated against the new window with address 0.
- Mid-frame frame_start: abandons current fetch, restarts at address 0; already-queued pipeline pixels still complete.
- fg_color/bg_color sampled at end of N+1, not latched per frame.
- rst mid-frame: pipeline flushed, pix_valid=0 next cycle, state IDLE.

Optional Feature:
LCD_ROM_BLINK_EN:
- Defined: 6-bit frame counter increments on each frame_start, wraps at BLINK_PERIOD-1, reset 0.
- When counter >= BLINK_PERIOD/2, in-window pixels output bg_color, but address counter still advances.
- Undefined: counter absent, image always shown.

Test Plan:
- rst, frame_start with win=(100,50), raster scan 480x272 with pix_req=1 -> rom_addr 0 at (100,50), 255 at (355,50), 256 at (100,51); frame_done once at (355,177); ROM bit=1 gives pix_data=fg_color exactly 2 cycles later.
- win_x0=400, win_y0=200 -> clamped to (224,144); first in-window pixel at (224,144), frame_done at (479,271).
- pix_req before any frame_start -> pix_valid at +2 with bg_color; rom_addr stays 0; active=0.
- frame_start mid-frame at address 1000, coincident with in-window pix_req -> that pixel uses address 0; counter=1 next cycle.
- pix_req gaps (alternate cycles) -> pix_valid mirrors pattern delayed 2 cycles; counter advances only on in-window requests.
- LCD_ROM_BLINK_EN defined, BLINK_PERIOD=4 -> frames 0,1 show image; frames 2,3 all bg_color; frame 4 shows image.

Source files
------------

// File: rtl/lcd_rom_window_ctrl.sv
// lcd_rom_window_ctrl: walks a 1bpp image ROM linearly while the LCD raster crosses a movable window,
// mapping each bit to fg/bg colour two cycles after the request. Optional macro LCD_ROM_BLINK_EN adds frame blinking.
module lcd_rom_window_ctrl #(
    parameter int H_DISP       = 480,
    parameter int V_DISP       = 272,
    parameter int IMG_W        = 256,
    parameter int IMG_H        = 128,
    parameter int ADDR_WIDTH   = 17,
    parameter int COLOR_W      = 16,
    parameter int BLINK_PERIOD = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  frame_start_i,
    input  logic                  pix_req_i,
    input  logic [10:0]           pix_x_i,
    input  logic [10:0]           pix_y_i,
    input  logic [10:0]           win_x0_i,
    input  logic [10:0]           win_y0_i,
    input  logic [COLOR_W-1:0]    fg_color_i,
    input  logic [COLOR_W-1:0]    bg_color_i,
    output logic [ADDR_WIDTH-1:0] rom_addr_o,
    input  logic                  rom_data_i,
    output logic [COLOR_W-1:0]    pix_data_o,
    output logic                  pix_valid_o,
    output logic                  frame_done_o,
    output logic                  active_o
);

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_e;

    localparam logic [10:0]           WX_MAX    = 11'(H_DISP - IMG_W);
    localparam logic [10:0]           WY_MAX    = 11'(V_DISP - IMG_H);
    localparam logic [11:0]           IMG_W_X   = 12'(IMG_W);
    localparam logic [11:0]           IMG_H_X   = 12'(IMG_H);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(IMG_W * IMG_H - 1);

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d, addr_cur;
    logic [10:0]             wx_q, wx_d, wy_q, wy_d;
    logic                    in_win, last_hit, fetching, show;
    logic                    in_win_d1_q, req_d1_q;
    logic [COLOR_W-1:0]      pix_data_q;
    logic                    pix_valid_q, frame_done_q, active_q;

    // A coincident frame_start takes effect in the same cycle: new window, address 0.
    always_comb begin
        wx_d     = frame_start_i ? ((win_x0_i > WX_MAX) ? WX_MAX : win_x0_i) : wx_q;
        wy_d     = frame_start_i ? ((win_y0_i > WY_MAX) ? WY_MAX : win_y0_i) : wy_q;
        addr_cur = frame_start_i ? '0 : addr_q;
        fetching = frame_start_i | (state_q == ACTIVE);
        in_win   = pix_req_i & fetching
                 & ({1'b0, pix_x_i} >= {1'b0, wx_d}) & ({1'b0, pix_x_i} < ({1'b0, wx_d} + IMG_W_X))
                 & ({1'b0, pix_y_i} >= {1'b0, wy_d}) & ({1'b0, pix_y_i} < ({1'b0, wy_d} + IMG_H_X));
        last_hit = in_win & (addr_cur == LAST_ADDR);
        addr_d   = (in_win & ~last_hit) ? addr_cur + 1'b1 : addr_cur;
    end

    assign rom_addr_o = addr_cur;

`ifdef LCD_ROM_BLINK_EN
    logic [5:0] blink_q, blink_d;

    // Blank decision uses the counter value that applies to the pixel's own frame.
    always_comb begin
        blink_d = blink_q;
        if (frame_start_i) begin
            blink_d = (blink_q == 6'(BLINK_PERIOD - 1)) ? 6'd0 : blink_q + 6'd1;
        end
        show = in_win & (blink_d < 6'(BLINK_PERIOD / 2));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            blink_q <= 6'd0;
        end else begin
            blink_q <= blink_d;
        end
    end
`else
    always_comb begin
        show = in_win;
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wx_q         <= '0;
            wy_q         <= '0;
            in_win_d1_q  <= 1'b0;
            req_d1_q     <= 1'b0;
            pix_data_q   <= '0;
            pix_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            active_q     <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (frame_start_i) begin
                state_q  <= ACTIVE;
                active_q <= 1'b1;
            end
            if (last_hit) begin
                state_q      <= DONE;
                active_q     <= 1'b0;
                frame_done_q <= 1'b1;
            end
            wx_q        <= wx_d;
            wy_q        <= wy_d;
            addr_q      <= addr_d;
            in_win_d1_q <= show;
            req_d1_q    <= pix_req_i;
            pix_valid_q <= req_d1_q;
            // pix_data holds its last colour through request gaps.
            if (req_d1_q) begin
                pix_data_q <= (in_win_d1_q & rom_data_i) ? fg_color_i : bg_color_i;
            end
        end
    end

    assign pix_data_o   = pix_data_q;
    assign pix_valid_o  = pix_valid_q;
    assign frame_done_o = frame_done_q;
    assign active_o     = active_q;

endmodule

// File: tb/tb_lcd_rom_window_ctrl.sv
// tb_lcd_rom_window_ctrl: raster, clamp, restart, gap and randomized traffic checked against a
// pixel-index model of the window fetch, plus literal pins taken from worked examples.
module tb_lcd_rom_window_ctrl;

    localparam int IMG_W = 256;
    localparam int IMG_H = 128;
    localparam int NPIX  = IMG_W * IMG_H;

    logic        clk = 1'b0;
    logic        rst, fs, req, rom_data;
    logic [10:0] px, py, wx0, wy0;
    logic [15:0] fg, bg, pix_data;
    logic [16:0] rom_addr;
    logic        pix_valid, frame_done, active;

    int total = 0;
    int bad   = 0;
    int scen  = -1;
    int doneCount = 0;

    logic [10:0] nWx = 11'd0, nWy = 11'd0;
    logic [15:0] nFg = 16'hF800, nBg = 16'h001F;

    lcd_rom_window_ctrl dut (
        .clk_i(clk), .rst_i(rst), .frame_start_i(fs), .pix_req_i(req),
        .pix_x_i(px), .pix_y_i(py), .win_x0_i(wx0), .win_y0_i(wy0),
        .fg_color_i(fg), .bg_color_i(bg), .rom_addr_o(rom_addr), .rom_data_i(rom_data),
        .pix_data_o(pix_data), .pix_valid_o(pix_valid), .frame_done_o(frame_done), .active_o(active)
    );

    always #5 clk = ~clk;

    function automatic logic romBit(input logic [16:0] a);
        return a[0] ^ a[2] ^ a[5] ^ a[9] ^ a[14];
    endfunction

    always @(posedge clk) rom_data <= romBit(rom_addr);

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input int s, input bit r, input bit f, input bit q, input int x, input int y);
        @(posedge clk);
        #1;
        scen = s; rst = r; fs = f; req = q;
        px = 11'(x); py = 11'(y);
        wx0 = nWx; wy0 = nWy; fg = nFg; bg = nBg;
    endtask

    // Model: which image pixel the frame has reached, and what each output must show.
    bit        modelReady = 0;
    int        mCount, mWx, mWy;
    bit        mActive, inWin;
    logic      expValid, expDone, expActive;
    logic [15:0] expData;
    bit        p1Req, p1Show;
    int        p1Addr, expAddr;
    bit        hReq0 = 0, hReq1 = 0;
    int        hX0 = 0, hY0 = 0, hX1 = 0, hY1 = 0;

    always @(negedge clk) begin
        if (modelReady) begin
            expAddr = fs ? 0 : mCount;
            checkOutput("rom_addr", 32'(rom_addr), 32'(expAddr));
            checkOutput("pix_valid", 32'(pix_valid), 32'(expValid));
            checkOutput("pix_data", 32'(pix_data), 32'(expData));
            checkOutput("frame_done", 32'(frame_done), 32'(expDone));
            checkOutput("active", 32'(active), 32'(expActive));
            if (scen == 0) begin
                checkOutput("pre_addr", 32'(rom_addr), 0);
                checkOutput("pre_active", 32'(active), 0);
                if (hReq1) checkOutput("pre_bg", 32'(pix_data), 32'h001F);
            end
            if (scen == 1 && req) begin
                if (px == 100 && py == 50) checkOutput("pin_addr0", 32'(rom_addr), 0);
                if (px == 355 && py == 50) checkOutput("pin_addr255", 32'(rom_addr), 255);
                if (px == 100 && py == 51) checkOutput("pin_addr256", 32'(rom_addr), 256);
            end
            if (scen == 1 && hReq0 && hX0 == 355 && hY0 == 177) checkOutput("pin_done", 32'(frame_done), 1);
            if (scen == 1 && hReq1 && hX1 == 101 && hY1 == 50) checkOutput("pin_fg", 32'(pix_data), 32'hF800);
            if (scen == 1 && hReq1 && hX1 == 100 && hY1 == 50) checkOutput("pin_bg", 32'(pix_data), 32'h001F);
            if (scen == 1 && frame_done === 1'b1) doneCount++;
            if (scen == 2 && req) begin
                if (px == 224 && py == 144) checkOutput("pin_clamp0", 32'(rom_addr), 0);
                if (px == 455 && py == 147) checkOutput("pin_999", 32'(rom_addr), 999);
                if (px == 456 && py == 147) checkOutput("pin_restart", 32'(rom_addr), 0);
                if (px == 457 && py == 147) checkOutput("pin_after", 32'(rom_addr), 1);
            end
            if (scen == 3) checkOutput("gap_valid", 32'(pix_valid), 32'(hReq1));
        end

        if (rst === 1'b1) begin
            modelReady = 1;
            mCount = 0; mWx = 0; mWy = 0; mActive = 0;
            expValid = 0; expData = 16'h0; expDone = 0; expActive = 0;
            p1Req = 0; p1Show = 0; p1Addr = 0;
        end else if (modelReady) begin
            if (p1Req) begin
                expValid = 1;
                expData  = (p1Show && romBit(17'(p1Addr))) ? fg : bg;
            end else begin
                expValid = 0;
            end
            if (fs) begin
                mWx = (int'(wx0) < 480 - IMG_W) ? int'(wx0) : 480 - IMG_W;
                mWy = (int'(wy0) < 272 - IMG_H) ? int'(wy0) : 272 - IMG_H;
                mCount = 0;
                mActive = 1;
            end
            inWin = req && mActive && int'(px) >= mWx && int'(px) < mWx + IMG_W
                    && int'(py) >= mWy && int'(py) < mWy + IMG_H;
            p1Req = req; p1Show = inWin; p1Addr = mCount;
            expDone = 0;
            if (inWin) begin
                if (mCount == NPIX - 1) begin
                    expDone = 1;
                    mActive = 0;
                end else begin
                    mCount++;
                end
            end
            expActive = mActive;
        end
        hReq1 = hReq0; hX1 = hX0; hY1 = hY0;
        hReq0 = (req === 1'b1); hX0 = int'(px); hY0 = int'(py);
    end

    initial begin
        rst = 1'b1; fs = 1'b0; req = 1'b0; px = '0; py = '0;
        wx0 = '0; wy0 = '0; fg = 16'hF800; bg = 16'h001F;
        repeat (3) applyStimulus(-1, 1, 0, 0, 0, 0);

        for (int i = 0; i < 20; i++)
            applyStimulus(0, 0, 0, bit'($urandom_range(0, 1)), $urandom_range(0, 479), $urandom_range(0, 271));

        nWx = 11'd100; nWy = 11'd50;
        applyStimulus(1, 0, 1, 0, 0, 0);
        for (int y = 48; y < 180; y++)
            for (int x = 98; x < 358; x++)
                applyStimulus(1, 0, 0, 1, x, y);
        repeat (4) applyStimulus(5, 0, 0, 0, 0, 0);
        checkOutput("done_pulses", 32'(doneCount), 1);

        nWx = 11'd400; nWy = 11'd200;
        applyStimulus(2, 0, 1, 0, 0, 0);
        for (int y = 143; y < 151; y++)
            for (int x = 220; x < 480; x++)
                applyStimulus(2, 0, (x == 456 && y == 147), 1, x, y);
        for (int y = 151; y < 153; y++)
            for (int x = 224; x < 480; x++)
                applyStimulus(3, 0, 0, bit'(x % 2), x, y);
        applyStimulus(4, 1, 0, 1, 300, 200);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                nFg = 16'($urandom); nBg = 16'($urandom);
            end
            nWx = 11'($urandom); nWy = 11'($urandom);
            applyStimulus(4, ($urandom_range(0, 399) == 0), ($urandom_range(0, 149) == 0),
                          ($urandom_range(0, 9) < 7), $urandom_range(0, 479), $urandom_range(0, 271));
        end

        repeat (4) applyStimulus(5, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
